// File: rtl/morse_receiver.sv
// Morse receiver: samples a serial light line once per time unit and decodes letters A-H.
// Optional HEX glyph output enabled with `define MORSE_RX_SEVENSEG_EN.
module morse_receiver #(
  parameter int TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       morse_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       error,
`ifdef MORSE_RX_SEVENSEG_EN
  output logic [6:0] hex,
`endif
  output logic       busy
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] tick_cnt;
  logic        tick;
  logic [3:0]  pattern, pat_n;
  logic [2:0]  elem_cnt, cnt_n;
  logic [2:0]  run_cnt, run_n;
  logic        err, err_n;
  logic        dec_ok, dec_bad;
  logic [2:0]  dec_code;
  logic [3:0]  hit;
  logic        is_dash, elem_bad;
  logic [2:0]  run_inc;

  // Returns {match, code}; element order first->last maps MSB->LSB.
  function automatic logic [3:0] lookup(
    input logic [2:0] n,
    input logic [3:0] p
  );
    logic [3:0] r;
    r = 4'b0000;
    case ({n, p})
      {3'd2, 4'b0001}: r = {1'b1, 3'd0};
      {3'd4, 4'b1000}: r = {1'b1, 3'd1};
      {3'd4, 4'b1010}: r = {1'b1, 3'd2};
      {3'd3, 4'b0100}: r = {1'b1, 3'd3};
      {3'd1, 4'b0000}: r = {1'b1, 3'd4};
      {3'd4, 4'b0010}: r = {1'b1, 3'd5};
      {3'd3, 4'b0110}: r = {1'b1, 3'd6};
      {3'd4, 4'b0000}: r = {1'b1, 3'd7};
      default:         r = 4'b0000;
    endcase
    return r;
  endfunction

  assign tick    = (tick_cnt == TICK_LAST);
  assign hit     = lookup(elem_cnt, pattern);
  assign is_dash = (run_cnt >= 3'd2);
  assign elem_bad = (run_cnt >= 3'd5) || (elem_cnt == 3'd4);
  assign run_inc = (run_cnt == 3'd7) ? 3'd7 : run_cnt + 3'd1;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pattern  <= 4'd0;
      elem_cnt <= 3'd0;
      run_cnt  <= 3'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      pattern  <= pat_n;
      elem_cnt <= cnt_n;
      run_cnt  <= run_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    pat_n    = pattern;
    cnt_n    = elem_cnt;
    run_n    = run_cnt;
    err_n    = err;
    dec_ok   = 1'b0;
    dec_bad  = 1'b0;
    dec_code = 3'd0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (morse_in) begin
            state_n = MARK;
            run_n   = 3'd1;
          end
        end
        MARK: begin
          if (morse_in) begin
            run_n = run_inc;
          end else begin
            state_n = SPACE;
            run_n   = 3'd1;
            if (elem_bad) begin
              pat_n   = 4'd0;
              cnt_n   = 3'd0;
              err_n   = 1'b1;
              dec_bad = 1'b1;
            end else begin
              pat_n = {pattern[2:0], is_dash};
              cnt_n = elem_cnt + 3'd1;
            end
          end
        end
        SPACE: begin
          if (morse_in) begin
            // While recovering from an error, light restarts the quiet count.
            if (err) begin
              run_n = 3'd0;
            end else begin
              state_n = MARK;
              run_n   = 3'd1;
            end
          end else if (run_cnt == 3'd2) begin
            state_n = IDLE;
            run_n   = 3'd0;
            pat_n   = 4'd0;
            cnt_n   = 3'd0;
            err_n   = 1'b0;
            if (!err) begin
              dec_ok   = hit[3];
              dec_bad  = !hit[3];
              dec_code = hit[2:0];
            end
          end else begin
            run_n = run_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      letter       <= 3'd0;
      letter_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      letter_valid <= dec_ok;
      error        <= dec_bad;
      if (dec_ok) begin
        letter <= dec_code;
      end
    end
  end

`ifdef MORSE_RX_SEVENSEG_EN
  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] glyph(input logic [2:0] c);
    logic [6:0] g;
    g = 7'h7F;
    case (c)
      3'd0:    g = 7'h08;
      3'd1:    g = 7'h03;
      3'd2:    g = 7'h46;
      3'd3:    g = 7'h21;
      3'd4:    g = 7'h06;
      3'd5:    g = 7'h0E;
      3'd6:    g = 7'h42;
      3'd7:    g = 7'h09;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hex <= 7'h7F;
    end else if (dec_ok) begin
      hex <= glyph(dec_code);
    end else if (dec_bad) begin
      hex <= 7'h7F;
    end
  end
`endif

endmodule
